// File: rtl/c1_dtack_gen_if.sv
// Bus-side signals of the C1 acknowledge generator: the CPU strobe, the
// decoder zone selects, the static zone configuration, the external ready,
// and the acknowledge/bus-error outputs.
interface c1_dtack_gen_if #(
  parameter int NZONES = 4,
  parameter int CNT_W  = 3
) ();
  logic                    nAS;
  logic [NZONES-1:0]       nZONE;
  logic [NZONES*CNT_W-1:0] WAIT_CFG;
  logic [NZONES-1:0]       EXT_EN;
  logic                    PDTACK;
  logic                    nDTACK;
  logic                    nBERR;
  logic [NZONES-1:0]       ZONE_HIT;

  // CPU/decoder side
  modport master (
    output nAS, nZONE, WAIT_CFG, EXT_EN, PDTACK,
    input  nDTACK, nBERR, ZONE_HIT
  );

  // Acknowledge generator side
  modport slave (
    input  nAS, nZONE, WAIT_CFG, EXT_EN, PDTACK,
    output nDTACK, nBERR, ZONE_HIT
  );
endinterface

// File: rtl/c1_dtack_gen.sv
// 68000 nDTACK/nBERR generator for the C1 I/O block. A bus cycle is
// acknowledged after the selected zone's wait count, optionally gated by
// PDTACK, and terminated with a bus error if it runs to the timeout.
//
// state | meaning
// IDLE  | no cycle in progress, waiting for nAS low
// WAIT  | counting down the zone's fixed wait states
// EXT   | wait states done, holding for PDTACK
// ACK   | nDTACK asserted until nAS rises
// ERR   | nBERR asserted until nAS rises
module c1_dtack_gen #(
  parameter int NZONES  = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              CLK_68KCLK,
  input  logic              nRESET,
  c1_dtack_gen_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_EXT  = 3'd2,
    S_ACK  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam bit            TO_EN  = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [NZONES-1:0] zone_q, zone_d;
  logic              ext_q, ext_d;

  logic [NZONES-1:0] sel_hit;
  logic [CNT_W-1:0]  sel_cfg;
  logic              sel_ext;
  logic              timeout_hit;

  // Priority-encode the zone selects; scanning downwards lets bit 0 win.
  always_comb begin
    sel_hit = '0;
    sel_cfg = '0;
    sel_ext = 1'b0;
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (!bus.nZONE[i]) begin
        sel_hit    = '0;
        sel_hit[i] = 1'b1;
        sel_cfg    = bus.WAIT_CFG[i*CNT_W +: CNT_W];
        sel_ext    = bus.EXT_EN[i];
      end
    end
  end

  // TO_CNT equals the number of edges since cycle start, so a match means
  // this edge is the timeout edge.
  assign timeout_hit = TO_EN && (to_cnt_q == TO_VAL);

  // Next-state logic; the zone, its wait count and EXT_EN are captured on
  // the cycle's first edge so later input changes have no effect.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    zone_d   = zone_q;
    ext_d    = ext_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.nAS) begin
          zone_d   = sel_hit;
          ext_d    = sel_ext;
          to_cnt_d = TO_W'(1);
          cnt_d    = '0;
          if (sel_cfg != '0) begin
            cnt_d   = sel_cfg - CNT_W'(1);
            state_d = S_WAIT;
          end else if (sel_ext && !bus.PDTACK) begin
            state_d = S_EXT;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (bus.nAS) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0 && (!ext_q || bus.PDTACK)) begin
          state_d = S_ACK;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          else             state_d = S_EXT;
        end
      end
      S_EXT: begin
        if (bus.nAS) begin
          state_d = S_IDLE;
        end else if (bus.PDTACK) begin
          state_d = S_ACK;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_ACK, S_ERR: begin
        if (bus.nAS) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Every return to IDLE (normal end or abort) drops the cycle context.
    if (state_d == S_IDLE) begin
      cnt_d    = '0;
      to_cnt_d = '0;
      zone_d   = '0;
      ext_d    = 1'b0;
    end
  end

  // State and cycle-context registers.
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      zone_q   <= '0;
      ext_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      zone_q   <= zone_d;
      ext_q    <= ext_d;
    end
  end

  // Outputs release combinationally the moment nAS rises.
  assign bus.nDTACK   = bus.nAS | (state_q != S_ACK);
  assign bus.nBERR    = bus.nAS | (state_q != S_ERR);
  assign bus.ZONE_HIT = zone_q;

endmodule

// File: tb/tb_c1_dtack_gen.sv
// Bench for c1_dtack_gen with TIMEOUT = 8: directed vector table, corner
// sequences (reset mid-wait, abort), then random cycles against a model.
module tb_c1_dtack_gen;
  localparam int NZ = 4;
  localparam int CW = 3;
  localparam int TO = 8;

  logic clk;
  logic nreset;
  int   total;
  int   passed;

  c1_dtack_gen_if #(.NZONES(NZ), .CNT_W(CW)) bus ();

  c1_dtack_gen #(.NZONES(NZ), .CNT_W(CW), .TIMEOUT(TO), .TO_W(7)) dut (
    .CLK_68KCLK(clk),
    .nRESET(nreset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  nz;
    logic [11:0] cfg;
    logic [3:0]  ee;
    int          pd_from;  // PDTACK high from this edge offset on; 16 = never
    logic [3:0]  hit;
    bit          err;
    int          edge_n;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the cycle acks at the first edge offset j >= n where ready
  // holds (always for non-ext zones, PDTACK for ext zones); if no such j
  // exists up to TIMEOUT, it errors at TIMEOUT.
  function automatic void model(input logic [3:0] nz, input logic [11:0] cfg,
                                input logic [3:0] ee, input logic [15:0] pd,
                                output logic [3:0] hit, output bit is_err,
                                output int edge_o);
    int z;
    int n;
    bit x;
    z = -1;
    n = 0;
    x = 1'b0;
    for (int i = NZ - 1; i >= 0; i--) if (!nz[i]) z = i;
    hit = '0;
    if (z >= 0) begin
      hit[z] = 1'b1;
      n = int'((cfg >> (CW * z)) & 12'h7);
      x = ee[z];
    end
    edge_o = -1;
    for (int j = n; j <= TO; j++) begin
      if (edge_o < 0 && (!x || pd[j])) edge_o = j;
    end
    is_err = (edge_o < 0);
    if (is_err) edge_o = TO;
  endfunction

  // One complete bus cycle starting at the next edge; pd bit e is the
  // PDTACK level presented to edge k+e. Inputs other than nAS/PDTACK are
  // scrambled after edge k to show they are ignored.
  task automatic run_cycle(input string name, input logic [3:0] nz, input logic [11:0] cfg,
                           input logic [3:0] ee, input logic [15:0] pd,
                           input logic [3:0] exp_hit, input bit exp_err,
                           input int exp_edge, input int extra);
    int last;
    last = exp_edge + extra;
    bus.nZONE    = nz;
    bus.WAIT_CFG = cfg;
    bus.EXT_EN   = ee;
    bus.PDTACK   = pd[0];
    bus.nAS      = 1'b0;
    for (int e = 0; e <= last; e++) begin
      step();
      chk($sformatf("%s hit e%0d", name, e), 32'(bus.ZONE_HIT), 32'(exp_hit));
      chk($sformatf("%s ndtack e%0d", name, e), 32'(bus.nDTACK),
          32'(!(!exp_err && e >= exp_edge)));
      chk($sformatf("%s nberr e%0d", name, e), 32'(bus.nBERR),
          32'(!(exp_err && e >= exp_edge)));
      if (e == 0) begin
        bus.nZONE    = 4'($urandom);
        bus.WAIT_CFG = 12'($urandom);
        bus.EXT_EN   = 4'($urandom);
      end
      bus.PDTACK = pd[e+1];
    end
    bus.nAS = 1'b1;
    #1;
    chk({name, " release ndtack"}, 32'(bus.nDTACK), 32'd1);
    chk({name, " release nberr"}, 32'(bus.nBERR), 32'd1);
    step();
    chk({name, " idle hit"}, 32'(bus.ZONE_HIT), 32'd0);
    bus.PDTACK = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] m;
    logic [3:0]  rh;
    bit          rerr;
    int          redge;
    logic [3:0]  rnz;
    logic [11:0] rcfg;
    logic [3:0]  ree;
    logic [15:0] rpd;

    total  = 0;
    passed = 0;

    //           nZONE     WAIT_CFG  EXT_EN   pd  hit      err  edge
    vecs[0]  = '{4'b1101, 12'h028, 4'b0000, 16, 4'b0010, 1'b0, 5};  // zone1 n=5
    vecs[1]  = '{4'b1111, 12'hFFF, 4'b1111, 16, 4'b0000, 1'b0, 0};  // unmapped
    vecs[2]  = '{4'b1010, 12'h182, 4'b0000, 16, 4'b0001, 1'b0, 2};  // zone0 beats zone2
    vecs[3]  = '{4'b1011, 12'h040, 4'b0100,  4, 4'b0100, 1'b0, 4};  // PDTACK at k+4
    vecs[4]  = '{4'b1011, 12'h040, 4'b0100,  8, 4'b0100, 1'b0, 8};  // ready on timeout edge
    vecs[5]  = '{4'b0111, 12'h000, 4'b1000, 16, 4'b1000, 1'b1, 8};  // timeout
    vecs[6]  = '{4'b0111, 12'h000, 4'b1000,  0, 4'b1000, 1'b0, 0};  // ext ready at once
    vecs[7]  = '{4'b1110, 12'h007, 4'b0000, 16, 4'b0001, 1'b0, 7};  // max wait
    vecs[8]  = '{4'b1101, 12'h018, 4'b0010,  1, 4'b0010, 1'b0, 3};  // ready before n
    vecs[9]  = '{4'b0111, 12'hE00, 4'b1000, 16, 4'b1000, 1'b1, 8};  // n=7 then timeout
    vecs[10] = '{4'b1110, 12'h002, 4'b1110, 16, 4'b0001, 1'b0, 2};  // other zones' EXT_EN

    nreset       = 1'b0;
    bus.nAS      = 1'b1;
    bus.nZONE    = 4'hF;
    bus.WAIT_CFG = '0;
    bus.EXT_EN   = '0;
    bus.PDTACK   = 1'b0;
    step();
    step();
    chk("reset ndtack", 32'(bus.nDTACK), 32'd1);
    chk("reset nberr", 32'(bus.nBERR), 32'd1);
    chk("reset hit", 32'(bus.ZONE_HIT), 32'd0);
    nreset = 1'b1;
    step();

    for (int v = 0; v < 11; v++) begin
      m = 32'hFFFF_FFFF << vecs[v].pd_from;
      run_cycle($sformatf("vec%0d", v), vecs[v].nz, vecs[v].cfg, vecs[v].ee, m[15:0],
                vecs[v].hit, vecs[v].err, vecs[v].edge_n, 2);
    end

    // Reset while CNT = 3 (two edges into a 5-wait cycle), nAS held low.
    bus.nZONE    = 4'b1101;
    bus.WAIT_CFG = 12'h028;
    bus.EXT_EN   = 4'b0000;
    bus.nAS      = 1'b0;
    step();
    step();
    chk("midwait hit before reset", 32'(bus.ZONE_HIT), 32'h2);
    nreset = 1'b0;
    #1;
    chk("midwait reset ndtack", 32'(bus.nDTACK), 32'd1);
    chk("midwait reset nberr", 32'(bus.nBERR), 32'd1);
    chk("midwait reset hit", 32'(bus.ZONE_HIT), 32'd0);
    for (int e = 0; e < 5; e++) begin
      step();
      chk("midwait held ndtack", 32'(bus.nDTACK), 32'd1);
      chk("midwait held hit", 32'(bus.ZONE_HIT), 32'd0);
    end
    bus.nAS = 1'b1;
    nreset  = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("post reset hit", 32'(bus.ZONE_HIT), 32'd0);
    end
    run_cycle("post reset cycle", 4'b1011, 12'h0C0, 4'b0000, 16'h0000, 4'b0100, 1'b0, 3, 1);

    // Abort: nAS rises while CNT = 2, then a clean 3-wait cycle.
    bus.nZONE    = 4'b1101;
    bus.WAIT_CFG = 12'h028;
    bus.EXT_EN   = 4'b0000;
    bus.nAS      = 1'b0;
    step();
    step();
    step();
    chk("abort pre hit", 32'(bus.ZONE_HIT), 32'h2);
    bus.nAS = 1'b1;
    step();
    chk("abort idle hit", 32'(bus.ZONE_HIT), 32'd0);
    for (int e = 0; e < 4; e++) begin
      step();
      chk("abort no ack hit", 32'(bus.ZONE_HIT), 32'd0);
    end
    run_cycle("after abort", 4'b1110, 12'h003, 4'b0000, 16'h0000, 4'b0001, 1'b0, 3, 2);

    // Random cycles against the reference model.
    for (int t = 0; t < 60; t++) begin
      rnz  = 4'($urandom);
      rcfg = 12'($urandom);
      ree  = 4'($urandom);
      rpd  = 16'($urandom & $urandom);
      model(rnz, rcfg, ree, rpd, rh, rerr, redge);
      run_cycle($sformatf("rand%0d", t), rnz, rcfg, ree, rpd, rh, rerr, redge,
                int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
